// File: rtl/ifm_wgt_streamer_if.sv
// Bundles the SRAM read ports and the PE-array input stream of ifm_wgt_streamer.
// master = streamer side, slave = memories / PE array side.
interface ifm_wgt_streamer_if #(
    parameter int IFM_DATA_WIDTH = 8,
    parameter int WGT_WORD_WIDTH = 72,
    parameter int ADDR_WIDTH     = 12
);
    logic                      ifm_ready;
    logic                      ifm_mem_rd_en;
    logic [ADDR_WIDTH-1:0]     ifm_mem_addr;
    logic [IFM_DATA_WIDTH-1:0] ifm_mem_rdata;
    logic                      wgt_mem_rd_en;
    logic [3:0]                wgt_mem_addr;
    logic [WGT_WORD_WIDTH-1:0] wgt_mem_rdata;
    logic [WGT_WORD_WIDTH-1:0] wgt;
    logic                      set_wgt;
    logic                      start_conv;
    logic [IFM_DATA_WIDTH-1:0] ifm;
    logic                      set_ifm;
    logic                      ifm_last;
    logic [3:0]                channel_num;

    modport master (
        input  ifm_ready, ifm_mem_rdata, wgt_mem_rdata,
        output ifm_mem_rd_en, ifm_mem_addr, wgt_mem_rd_en, wgt_mem_addr,
               wgt, set_wgt, start_conv, ifm, set_ifm, ifm_last, channel_num
    );
    modport slave (
        output ifm_ready, ifm_mem_rdata, wgt_mem_rdata,
        input  ifm_mem_rd_en, ifm_mem_addr, wgt_mem_rd_en, wgt_mem_addr,
               wgt, set_wgt, start_conv, ifm, set_ifm, ifm_last, channel_num
    );
endinterface

// File: rtl/ifm_wgt_streamer.sv
// Streams one weight word then the raster-ordered feature map per channel into the PE array.
// Optional IFM_ZERO_PAD_EN wraps each channel in a 1-pixel zero border.
module ifm_wgt_streamer #(
    parameter int IFM_DATA_WIDTH = 8,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int KERNEL_SIZE    = 3,
    parameter int IFM_WIDTH      = 9,
    parameter int IFM_HEIGHT     = 9,
    parameter int NUM_CHANNEL    = 3,
    parameter int ADDR_WIDTH     = 12
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 start,
    ifm_wgt_streamer_if.master   bus,
    output logic                 busy,
    output logic                 done
);
    localparam int WW = KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH;
`ifdef IFM_ZERO_PAD_EN
    localparam int GRID_W = IFM_WIDTH + 2;
    localparam int GRID_H = IFM_HEIGHT + 2;
`else
    localparam int GRID_W = IFM_WIDTH;
    localparam int GRID_H = IFM_HEIGHT;
`endif
    localparam int CW = $clog2(GRID_W);
    localparam int RW = $clog2(GRID_H);

    typedef enum logic [2:0] {IDLE, LOAD_WGT, WGT_WAIT, STREAM, DRAIN, DONE} state_t;
    state_t state, next;

    logic [3:0]            ch;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WW-1:0]         wgt_q;
    logic                  set_wgt_q, start_conv_q;

    // In-flight token: a read issued last cycle whose data lands in the FIFO this cycle.
    logic inflight, inflight_last;
    logic [IFM_DATA_WIDTH-1:0] fifo_data [2];
    logic                      fifo_last [2];
    logic                      wr_ptr, rd_ptr;
    logic [1:0]                cnt;

    logic issue, rd_en, pop, at_last, drained;
    logic [2:0] occ;
    logic [IFM_DATA_WIDTH-1:0] pix_in;

    assign at_last = (row == RW'(GRID_H - 1)) && (col == CW'(GRID_W - 1));
    assign pop     = (cnt != 2'd0) && bus.ifm_ready;
    assign occ     = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
    assign drained = !inflight && ((cnt == 2'd0) || (pop && cnt == 2'd1));

`ifdef IFM_ZERO_PAD_EN
    logic is_pad, inflight_zero;
    assign is_pad = (row == '0) || (col == '0) ||
                    (row == RW'(GRID_H - 1)) || (col == CW'(GRID_W - 1));
    assign rd_en  = issue && !is_pad;
    assign pix_in = inflight_zero ? '0 : bus.ifm_mem_rdata;
`else
    assign rd_en  = issue;
    assign pix_in = bus.ifm_mem_rdata;
`endif

    always_comb begin
        next  = state;
        issue = 1'b0;
        case (state)
            IDLE:     if (start) next = LOAD_WGT;
            LOAD_WGT: next = WGT_WAIT;
            WGT_WAIT: next = STREAM;
            STREAM: begin
                issue = (occ < 3'd2);
                if (issue && at_last) next = DRAIN;
            end
            DRAIN:    if (drained) next = (ch == 4'(NUM_CHANNEL - 1)) ? DONE : LOAD_WGT;
            DONE:     next = IDLE;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state         <= IDLE;
            ch            <= '0;
            row           <= '0;
            col           <= '0;
            addr          <= '0;
            wgt_q         <= '0;
            set_wgt_q     <= 1'b0;
            start_conv_q  <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            cnt           <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
`ifdef IFM_ZERO_PAD_EN
            inflight_zero <= 1'b0;
`endif
        end else begin
            state        <= next;
            set_wgt_q    <= 1'b0;
            start_conv_q <= 1'b0;
            if (state == IDLE) begin
                ch   <= '0;
                row  <= '0;
                col  <= '0;
                addr <= '0;
            end
            if (state == WGT_WAIT) begin
                wgt_q        <= bus.wgt_mem_rdata;
                set_wgt_q    <= 1'b1;
                start_conv_q <= (ch == 4'd0);
            end
            if (state == DRAIN && drained && ch != 4'(NUM_CHANNEL - 1)) ch <= ch + 4'd1;
            if (issue) begin
                if (col == CW'(GRID_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(GRID_H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (rd_en) addr <= addr + ADDR_WIDTH'(1);
            inflight      <= issue;
            inflight_last <= issue && at_last;
`ifdef IFM_ZERO_PAD_EN
            inflight_zero <= issue && is_pad;
`endif
            if (inflight) begin
                fifo_data[wr_ptr] <= pix_in;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

    assign bus.ifm_mem_rd_en = rd_en;
    assign bus.ifm_mem_addr  = addr;
    assign bus.wgt_mem_rd_en = (state == LOAD_WGT);
    assign bus.wgt_mem_addr  = ch;
    assign bus.wgt           = wgt_q;
    assign bus.set_wgt       = set_wgt_q;
    assign bus.start_conv    = start_conv_q;
    assign bus.ifm           = fifo_data[rd_ptr];
    assign bus.set_ifm       = pop;
    assign bus.ifm_last      = pop && fifo_last[rd_ptr];
    assign bus.channel_num   = ch;
    assign busy              = (state != IDLE);
    assign done              = (state == DONE);
endmodule
